// File: rtl/serial_chunk_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_chunk_adder_if
// Description : Start/done handshake and operand/result bundle for
//               serial_chunk_adder. The optional subtract request
//               appears when SERIAL_CHUNK_ADDER_SUB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_chunk_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Requester side: issues operations and observes results
  modport master (
    output start, a, b, cin,
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    output sub,
`endif
    input  busy, done, sum, cout
  );

  // Adder side: accepts operations and returns results
  modport slave (
    input  start, a, b, cin,
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    input  sub,
`endif
    output busy, done, sum, cout
  );
endinterface
`default_nettype wire

// File: rtl/serial_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_chunk_adder
// Description : Multi-cycle unsigned adder. Adds two WIDTH-bit operands plus
//               carry-in, CHUNK bits per clock from the LSB upward, and
//               commits sum/cout in one step at the end of the pass.
//               Optional macro SERIAL_CHUNK_ADDER_SUB_EN adds a 'sub' request
//               that computes a-b (cout=1 means no borrow).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_chunk_adder_if.slave  bus
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   psum_q, psum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [CHUNK:0]     chunk_sum;
  logic [WIDTH-1:0]   psum_next;
  logic [WIDTH-1:0]   b_load;
  logic               carry_load;

  // Operand B and initial carry as seen by the datapath (inverted for subtract)
  always_comb begin
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    b_load     = bus.sub ? ~bus.b : bus.b;
    carry_load = bus.sub ? 1'b1   : bus.cin;
`else
    b_load     = bus.b;
    carry_load = bus.cin;
`endif
  end

  // One chunk of addition and the partial sum with the new chunk shifted in at the top
  always_comb begin
    chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
              + {{CHUNK{1'b0}}, carry_q};
    psum_next = (psum_q >> CHUNK)
              | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
  end

  // Next-state and datapath update; outputs derive from the next state so they are registered
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    psum_d  = psum_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = b_load;
          carry_d = carry_load;
          psum_d  = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = chunk_sum[CHUNK];
        psum_d  = psum_next;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Result becomes visible only here, in a single step
          sum_d   = psum_next;
          cout_d  = chunk_sum[CHUNK];
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      psum_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      psum_q  <= psum_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_chunk_adder
// Description : Bench for serial_chunk_adder with WIDTH=8 at CHUNK=1, 4 and 8,
//               all three driven with the same operations in parallel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_chunk_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_chunk_adder_if #(.WIDTH(8)) if1 ();
  serial_chunk_adder_if #(.WIDTH(8)) if4 ();
  serial_chunk_adder_if #(.WIDTH(8)) if8 ();

  serial_chunk_adder #(.WIDTH(8), .CHUNK(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  serial_chunk_adder #(.WIDTH(8), .CHUNK(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

  // Number of RUN edges per instance
  int NS [3] = '{8, 2, 1};

  logic       busy_v [3];
  logic       done_v [3];
  logic [7:0] sum_v  [3];
  logic       cout_v [3];
  assign busy_v[0] = if1.busy;  assign busy_v[1] = if4.busy;  assign busy_v[2] = if8.busy;
  assign done_v[0] = if1.done;  assign done_v[1] = if4.done;  assign done_v[2] = if8.done;
  assign sum_v[0]  = if1.sum;   assign sum_v[1]  = if4.sum;   assign sum_v[2]  = if8.sum;
  assign cout_v[0] = if1.cout;  assign cout_v[1] = if4.cout;  assign cout_v[2] = if8.cout;

  // Last committed result each instance should be holding: {cout, sum}
  logic [8:0] exp_prev [3];

  // Reference: plain integer arithmetic on the operands
  function automatic logic [8:0] model(logic [7:0] a, logic [7:0] b, logic c, logic sb);
    int s;
    if (sb) begin
      s = int'(a) - int'(b);
      return {(a >= b), 8'(s)};
    end
    s = int'(a) + int'(b) + int'(c);
    return {(s >= 256), 8'(s)};
  endfunction

  task automatic chk(string tag, int idx, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[c%0d] observed=0x%0h expected=0x%0h", tag, idx, obs, exp);
    end
  endtask

  task automatic set_in(logic s, logic [7:0] a, logic [7:0] b, logic c, logic sb);
    if1.start = s; if1.a = a; if1.b = b; if1.cin = c;
    if4.start = s; if4.a = a; if4.b = b; if4.cin = c;
    if8.start = s; if8.a = a; if8.b = b; if8.cin = c;
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    if1.sub = sb; if4.sub = sb; if8.sub = sb;
`else
    if (sb) $display("note: subtract requested without subtract support");
`endif
  endtask

  task automatic check_all_zero(string tag);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_busy"}, i, 32'(busy_v[i]), 32'd0);
      chk({tag, "_done"}, i, 32'(done_v[i]), 32'd0);
      chk({tag, "_sum"},  i, 32'(sum_v[i]),  32'd0);
      chk({tag, "_cout"}, i, 32'(cout_v[i]), 32'd0);
    end
  endtask

  // One operation on all instances; start optionally held (with other operands)
  // for 'hold' cycles after acceptance. Only instances in 'mask' are judged.
  task automatic run_op(string tag, logic [7:0] a, logic [7:0] b, logic c, logic sb,
                        int hold, logic [7:0] alt_a, logic [7:0] alt_b, logic [2:0] mask);
    int         busy_cnt [3];
    int         done_cnt [3];
    int         first    [3];
    bit         held_ok  [3];
    logic [8:0] exp;
    exp = model(a, b, c, sb);
    for (int i = 0; i < 3; i++) begin
      busy_cnt[i] = 0; done_cnt[i] = 0; first[i] = -1; held_ok[i] = 1'b1;
    end
    @(negedge clk);
    set_in(1'b1, a, b, c, sb);
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      if (k < hold) set_in(1'b1, alt_a, alt_b, ~c, sb);
      else          set_in(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), sb);
      for (int i = 0; i < 3; i++) begin
        if (busy_v[i]) busy_cnt[i]++;
        if (done_v[i]) begin
          if (first[i] < 0) first[i] = k;
          done_cnt[i]++;
        end
        if (first[i] < 0 && {cout_v[i], sum_v[i]} !== exp_prev[i]) held_ok[i] = 1'b0;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 3; i++) begin
      if (mask[i]) begin
        chk({tag, "_latency"}, i, 32'(first[i]), 32'(NS[i]));
        chk({tag, "_busycyc"}, i, 32'(busy_cnt[i]), 32'(NS[i]));
        chk({tag, "_donecnt"}, i, 32'(done_cnt[i]), 32'd1);
        chk({tag, "_hold"},    i, 32'(held_ok[i]), 32'd1);
        chk({tag, "_sum"},     i, 32'(sum_v[i]),  32'(exp[7:0]));
        chk({tag, "_cout"},    i, 32'(cout_v[i]), 32'(exp[8]));
        exp_prev[i] = exp;
      end
    end
  endtask

  initial begin
    logic [8:0] e;
    int         dcnt;
    int         dfirst;
    logic [7:0] ra, rb;
    logic       rc, rs;

    for (int i = 0; i < 3; i++) exp_prev[i] = 9'h000;
    set_in(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

    // Reset state, during and after reset
    repeat (2) @(negedge clk);
    check_all_zero("reset_hold");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset_rel");

    // Directed arithmetic
    run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 0, 8'h00, 8'h00, 3'b111);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 0, 8'h00, 8'h00, 3'b111);
    run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 0, 8'h00, 8'h00, 3'b111);
    run_op("add_80_80", 8'h80, 8'h80, 1'b0, 1'b0, 0, 8'h00, 8'h00, 3'b111);
    run_op("add_zero", 8'h00, 8'h00, 1'b0, 1'b0, 0, 8'h00, 8'h00, 3'b111);

    // Start held through RUN with new operands: CHUNK=1 must keep the first pair;
    // the shorter instances re-accept and finish on the held operands
    run_op("hold_start", 8'h12, 8'h34, 1'b0, 1'b0, 7, 8'hAA, 8'h55, 3'b001);
    e = model(8'hAA, 8'h55, 1'b1, 1'b0);
    for (int i = 1; i < 3; i++) begin
      chk("hold_reaccept_sum",  i, 32'(sum_v[i]),  32'(e[7:0]));
      chk("hold_reaccept_cout", i, 32'(cout_v[i]), 32'(e[8]));
      exp_prev[i] = e;
    end

    // Back-to-back on CHUNK=1: new start in the DONE cycle
    @(negedge clk);
    set_in(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
    @(negedge clk);
    set_in(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    chk("b2b_done1", 0, 32'(done_v[0]), 32'd1);
    chk("b2b_sum1",  0, 32'(sum_v[0]),  32'h33);
    set_in(1'b1, 8'h40, 8'h05, 1'b1, 1'b0);
    @(negedge clk);
    set_in(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("b2b_done_drop", 0, 32'(done_v[0]), 32'd0);
    chk("b2b_busy2",     0, 32'(busy_v[0]), 32'd1);
    dcnt = 0; dfirst = -1;
    for (int k = 0; k < 10; k++) begin
      if (done_v[0]) begin
        if (dfirst < 0) dfirst = k;
        dcnt++;
      end
      @(negedge clk);
    end
    chk("b2b_latency2", 0, 32'(dfirst), 32'd8);
    chk("b2b_donecnt2", 0, 32'(dcnt),   32'd1);
    e = model(8'h40, 8'h05, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_sum2",  i, 32'(sum_v[i]),  32'(e[7:0]));
      chk("b2b_cout2", i, 32'(cout_v[i]), 32'(e[8]));
      exp_prev[i] = e;
    end

    // Reset after 3 RUN edges of 0x5A+0x3C
    @(negedge clk);
    set_in(1'b1, 8'h5A, 8'h3C, 1'b0, 1'b0);
    @(negedge clk);
    set_in(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("midrst_running", 0, 32'(busy_v[0]), 32'd1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) exp_prev[i] = 9'h000;
    run_op("after_rst", 8'h01, 8'h02, 1'b0, 1'b0, 0, 8'h00, 8'h00, 3'b111);

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
    run_op("sub_10_20", 8'h10, 8'h20, 1'b0, 1'b1, 0, 8'h00, 8'h00, 3'b111);
    run_op("sub_20_10", 8'h20, 8'h10, 1'b1, 1'b1, 0, 8'h00, 8'h00, 3'b111);
`endif

    // Randomized operations
    for (int n = 0; n < 20; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      run_op("random", ra, rb, rc, rs, 0, 8'h00, 8'h00, 3'b111);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
